deco_fetch_seq: RTL and testbench

//  Sequencer wrapped around the instruction decoder. Fetches one word from

---
 rtl/deco_fetch_seq.sv | 135 +++++++++++++
 tb/tb_deco_fetch_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deco_fetch_seq.sv
// rtl/deco_fetch_seq.sv - fetch/decode/issue sequencer around the instruction decoder
module deco_fetch_seq #(
    parameter int          TIMEOUT      = 16,
    parameter int          CNT_W        = 5,
    parameter logic [31:0] INSTRET_INIT = 32'h0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata,
    output logic [31:0] dec_inst,
    output logic        dec_enable,
    output logic        dec_reset,
    input  logic [11:0] codif,
    output logic        issue_valid,
    input  logic        issue_ready,
    input  logic        exec_done,
    output logic        trap_valid,
    output logic [1:0]  trap_cause,
    input  logic        trap_ack,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_CHECK, S_ISSUE, S_EXEC, S_TRAP
    } state_t;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0]  CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0]  CAUSE_FETCH    = 2'd3;
    localparam logic [11:0] ILLEGAL_CODE   = 12'hFFF;

    state_t           state, state_d;
    logic [CNT_W-1:0] tcnt;
    logic             start_fetch;
    logic             retire;
    logic [1:0]       cause_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d     = state;
        start_fetch = 1'b0;
        retire      = 1'b0;
        cause_d     = 2'd0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    if (pc[1:0] != 2'b00) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = S_FETCH;
                        start_fetch = 1'b1;
                    end
                end
            end
            // error beats ack, ack beats the timeout on the final cycle
            S_FETCH: begin
                if (mem_err) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH;
                end else if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH;
                end
            end
            S_DECODE: state_d = S_CHECK;
            S_CHECK: begin
                if (codif == ILLEGAL_CODE) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: if (issue_ready) state_d = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    retire = 1'b1;
                    if (!run) begin
                        state_d = S_IDLE;
                    end else if (pc[1:0] != 2'b00) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d     = S_FETCH;
                        start_fetch = 1'b1;
                    end
                end
            end
            S_TRAP: if (trap_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tcnt       <= '0;
            mem_addr   <= 32'h0;
            dec_inst   <= 32'h0;
            instret    <= INSTRET_INIT;
            trap_cause <= 2'd0;
        end else begin
            tcnt <= (state == S_FETCH) ? tcnt + CNT_W'(1) : '0;
            if (start_fetch)
                mem_addr <= pc;
            if (state == S_FETCH && mem_ack && !mem_err)
                dec_inst <= mem_rdata;
            if (retire)
                instret <= instret + 32'd1;
            if (state != S_TRAP)
                trap_cause <= (state_d == S_TRAP) ? cause_d : 2'd0;
            else if (trap_ack)
                trap_cause <= 2'd0;
        end
    end

    assign mem_req     = (state == S_FETCH);
    assign dec_enable  = (state == S_DECODE);
    assign dec_reset   = (state == S_IDLE);
    assign issue_valid = (state == S_ISSUE);
    assign trap_valid  = (state == S_TRAP);

endmodule

// File: tb/tb_deco_fetch_seq.sv
// tb/tb_deco_fetch_seq.sv - directed self-checking bench for deco_fetch_seq
module tb_deco_fetch_seq;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        mem_ack = 1'b0;
    logic        mem_err = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        issue_ready = 1'b0;
    logic        exec_done = 1'b0;
    logic        trap_ack = 1'b0;
    logic [11:0] codif = 12'h0;

    logic        mem_req, dec_enable, dec_reset, issue_valid, trap_valid;
    logic [31:0] mem_addr, dec_inst, instret;
    logic [1:0]  trap_cause;

    logic        w_mem_req, w_dec_enable, w_dec_reset, w_issue_valid, w_trap_valid;
    logic [31:0] w_mem_addr, w_dec_inst, w_instret;
    logic [1:0]  w_trap_cause;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    // decoder stand-in: registered, codif is the top 12 bits of the word
    always @(posedge clock) begin
        if (dec_reset)       codif <= 12'h0;
        else if (dec_enable) codif <= dec_inst[31:20];
    end

    deco_fetch_seq dut (
        .clock(clock), .resetn(resetn), .run(run), .pc(pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err),
        .mem_rdata(mem_rdata), .dec_inst(dec_inst), .dec_enable(dec_enable),
        .dec_reset(dec_reset), .codif(codif), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .exec_done(exec_done), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_ack(trap_ack), .instret(instret)
    );

    deco_fetch_seq #(.INSTRET_INIT(32'hFFFF_FFFF)) dut_wrap (
        .clock(clock), .resetn(resetn), .run(run), .pc(pc),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_ack(mem_ack), .mem_err(mem_err),
        .mem_rdata(mem_rdata), .dec_inst(w_dec_inst), .dec_enable(w_dec_enable),
        .dec_reset(w_dec_reset), .codif(codif), .issue_valid(w_issue_valid),
        .issue_ready(issue_ready), .exec_done(exec_done), .trap_valid(w_trap_valid),
        .trap_cause(w_trap_cause), .trap_ack(trap_ack), .instret(w_instret)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] addr);
        run = 1'b1;
        pc  = addr;
        step();
        run = 1'b0;
    endtask

    task automatic clear_trap();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (dec_reset !== 1'b1) begin n_fail++; $display("FAIL reset_dec_reset: got %b want 1", dec_reset); end
        n_checks++; if ({dec_enable, issue_valid, trap_valid, trap_cause} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {dec_enable, issue_valid, trap_valid, trap_cause}); end
        n_checks++; if ({mem_addr, dec_inst, instret} !== 96'h0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", {mem_addr, dec_inst, instret}); end
        n_checks++; if (w_instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_preset: got %h want ffffffff", w_instret); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        start_fetch(32'h100);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL basic_fetch: got req=%b addr=%h want 1 00000100", mem_req, mem_addr); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        mem_ack = 1'b0;
        n_checks++; if (dec_enable !== 1'b1 || dec_reset !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_decode: got en=%b rst=%b req=%b want 1 0 0", dec_enable, dec_reset, mem_req); end
        n_checks++; if (dec_inst !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_inst: got %h want 00500093", dec_inst); end
        step();
        n_checks++; if (dec_enable !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL basic_check: got en=%b iv=%b want 0 0", dec_enable, issue_valid); end
        step();
        n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL basic_issue_latency: got %b want 1", issue_valid); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || instret !== 32'd0) begin n_fail++; $display("FAIL basic_exec: got iv=%b instret=%0d want 0 0", issue_valid, instret); end
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        n_checks++; if (instret !== 32'd1 || dec_reset !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_retire: got instret=%0d rst=%b req=%b want 1 1 0", instret, dec_reset, mem_req); end
    endtask

    task automatic test_illegal();
        start_fetch(32'h200);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        step();
        step();
        n_checks++; if (trap_valid !== 1'b1 || trap_cause !== 2'd2) begin n_fail++; $display("FAIL illegal_trap: got tv=%b cause=%0d want 1 2", trap_valid, trap_cause); end
        n_checks++; if (issue_valid !== 1'b0 || instret !== 32'd1) begin n_fail++; $display("FAIL illegal_noissue: got iv=%b instret=%0d want 0 1", issue_valid, instret); end
        step();
        n_checks++; if (trap_valid !== 1'b1 || trap_cause !== 2'd2) begin n_fail++; $display("FAIL illegal_hold: got tv=%b cause=%0d want 1 2", trap_valid, trap_cause); end
        clear_trap();
        n_checks++; if (trap_valid !== 1'b0 || trap_cause !== 2'd0 || dec_reset !== 1'b1) begin n_fail++; $display("FAIL illegal_exit: got tv=%b cause=%0d rst=%b want 0 0 1", trap_valid, trap_cause, dec_reset); end
    endtask

    task automatic test_misaligned();
        start_fetch(32'h102);
        n_checks++; if (mem_req !== 1'b0 || trap_valid !== 1'b1 || trap_cause !== 2'd1) begin n_fail++; $display("FAIL misalign_trap: got req=%b tv=%b cause=%0d want 0 1 1", mem_req, trap_valid, trap_cause); end
        clear_trap();
        n_checks++; if (mem_req !== 1'b0 || trap_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_exit: got req=%b tv=%b want 0 0", mem_req, trap_valid); end
    endtask

    task automatic test_timeout();
        logic held;
        held = 1'b1;
        start_fetch(32'h300);
        repeat (15) begin
            step();
            if (mem_req !== 1'b1 || trap_valid !== 1'b0) held = 1'b0;
        end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL timeout_wait: got %b want 1", held); end
        step();
        n_checks++; if (trap_valid !== 1'b1 || trap_cause !== 2'd3 || mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_trap: got tv=%b cause=%0d req=%b want 1 3 0", trap_valid, trap_cause, mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        n_checks++; if (dec_inst !== 32'hFFFF_FFFF || trap_cause !== 2'd3) begin n_fail++; $display("FAIL late_ack: got inst=%h cause=%0d want ffffffff 3", dec_inst, trap_cause); end
        clear_trap();
        start_fetch(32'h400);
        mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0; mem_err = 1'b0;
        n_checks++; if (trap_valid !== 1'b1 || trap_cause !== 2'd3 || dec_inst !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL ack_err: got tv=%b cause=%0d inst=%h want 1 3 ffffffff", trap_valid, trap_cause, dec_inst); end
        clear_trap();
    endtask

    task automatic test_backpressure();
        logic stable;
        logic quiet;
        stable = 1'b1;
        quiet  = 1'b1;
        start_fetch(32'h500);
        repeat (15) step();
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
        step();
        mem_ack = 1'b0;
        n_checks++; if (dec_enable !== 1'b1 || trap_valid !== 1'b0) begin n_fail++; $display("FAIL last_cycle_ack: got en=%b tv=%b want 1 0", dec_enable, trap_valid); end
        step();
        step();
        exec_done = 1'b1;
        repeat (5) begin
            step();
            if (issue_valid !== 1'b1 || dec_inst !== 32'h00A0_0113) stable = 1'b0;
        end
        exec_done = 1'b0;
        n_checks++; if (stable !== 1'b1 || instret !== 32'd1) begin n_fail++; $display("FAIL stall_stable: got stable=%b instret=%0d want 1 1", stable, instret); end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        repeat (3) begin
            if (mem_req !== 1'b0 || dec_reset !== 1'b1) quiet = 1'b0;
            step();
        end
        n_checks++; if (quiet !== 1'b1 || instret !== 32'd2) begin n_fail++; $display("FAIL run0_idle: got quiet=%b instret=%0d want 1 2", quiet, instret); end
    endtask

    task automatic test_back_to_back();
        run = 1'b1; pc = 32'h600;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0030_0193;
        step();
        mem_ack = 1'b0;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_no_rereq: got %b want 0", mem_req); end
        step();
        step();
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        pc = 32'h604; exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h604 || instret !== 32'd3) begin n_fail++; $display("FAIL b2b_refetch: got req=%b addr=%h instret=%0d want 1 00000604 3", mem_req, mem_addr, instret); end
        mem_ack = 1'b1; mem_rdata = 32'h0040_0213;
        step();
        mem_ack = 1'b0;
        step();
        step();
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        pc = 32'h606; exec_done = 1'b1;
        step();
        exec_done = 1'b0; run = 1'b0;
        n_checks++; if (trap_valid !== 1'b1 || trap_cause !== 2'd1 || instret !== 32'd4 || mem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_misalign: got tv=%b cause=%0d instret=%0d req=%b want 1 1 4 0", trap_valid, trap_cause, instret, mem_req); end
        clear_trap();
    endtask

    task automatic test_reset_mid_fetch();
        start_fetch(32'h700);
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %b want 1", mem_req); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || dec_reset !== 1'b1 || mem_addr !== 32'h0 || instret !== 32'h0) begin n_fail++; $display("FAIL midrst_async: got req=%b rst=%b addr=%h instret=%h want 0 1 0 0", mem_req, dec_reset, mem_addr, instret); end
        n_checks++; if (w_instret !== 32'hFFFF_FFFF || w_mem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_preset: got instret=%h req=%b want ffffffff 0", w_instret, w_mem_req); end
        step();
        resetn = 1'b1;
        step();
        start_fetch(32'h800);
        mem_ack = 1'b1; mem_rdata = 32'h0010_0073;
        step();
        mem_ack = 1'b0;
        step();
        step();
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        n_checks++; if (w_instret !== 32'h0 || instret !== 32'd1) begin n_fail++; $display("FAIL instret_wrap: got wrap=%h plain=%h want 00000000 00000001", w_instret, instret); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_misaligned();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
